// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter with a one-hot ring priority pointer and registered one-hot grant.
// Optional grant-length limit with timeout pulse: define RR_ARB_TIMEOUT_EN.
module rr_ring_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned IDW      = 2,
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           busy,
  output logic           timeout
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  if (N < 2 || IDW != $clog2(N) || HOLD_MAX < 1) begin : g_bad_params
    $error("rr_ring_arbiter: need N >= 2, IDW == clog2(N), HOLD_MAX >= 1");
  end

  logic [0:0]     state_q, state_d;
  logic [N-1:0]   ptr_q, ptr_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [IDW-1:0] gid_q, gid_d;

  logic           found;
  logic [IDW-1:0] win_idx;
  int unsigned    ptr_idx;
  logic [N-1:0]   ptr_next;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(HOLD_MAX + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
`endif

  // Scan requests starting at the pointer position, wrapping N-1 -> 0.
  always_comb begin
    ptr_idx = 0;
    for (int unsigned i = 0; i < N; i++) begin
      if (ptr_q[i]) ptr_idx = i;
    end
    found   = 1'b0;
    win_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && req[(ptr_idx + k) % N]) begin
        found   = 1'b1;
        win_idx = IDW'((ptr_idx + k) % N);
      end
    end
  end

  assign ptr_next = {grant_q[N-2:0], grant_q[N-1]};

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    gid_d   = gid_q;
`ifdef RR_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (en && found) begin
          state_d          = S_GRANT;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          gid_d            = win_idx;
`ifdef RR_ARB_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      S_GRANT: begin
        if (!req[gid_q]) begin
          state_d = S_IDLE;
          grant_d = '0;
          gid_d   = '0;
          ptr_d   = ptr_next;
        end
`ifdef RR_ARB_TIMEOUT_EN
        // cnt_q counts completed grant cycles, so HOLD_MAX-1 marks the last one.
        else if (cnt_q == CW'(HOLD_MAX - 1)) begin
          state_d   = S_IDLE;
          grant_d   = '0;
          gid_d     = '0;
          ptr_d     = ptr_next;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        gid_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= {{(N-1){1'b0}}, 1'b1};
      grant_q <= '0;
      gid_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      gid_q   <= gid_d;
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign grant    = grant_q;
  assign grant_id = gid_q;
  assign busy     = |grant_q;

endmodule

// File: tb/tb_rr_ring_arbiter.sv
// Scoreboard bench for rr_ring_arbiter (N=4, HOLD_MAX=8); honours RR_ARB_TIMEOUT_EN.
module tb_rr_ring_arbiter;

  localparam int N    = 4;
  localparam int HOLD = 8;

  logic       clk;
  logic       reset;
  logic       en;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout;

  rr_ring_arbiter #(.N(4), .IDW(2), .HOLD_MAX(8)) dut (
    .clk(clk), .reset(reset), .en(en), .req(req),
    .grant(grant), .grant_id(grant_id), .busy(busy), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] g;
    logic [1:0] id;
    logic       b;
    logic       to;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: pointer kept as an integer position, age = visible grant cycles.
  int m_ptr, m_owner, m_age;
  bit m_busy, m_to;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_age = 0; m_busy = 0; m_to = 0;
  endtask

  task automatic model_step(input logic rst_in, input logic e, input logic [3:0] r);
    bit tmo_en;
`ifdef RR_ARB_TIMEOUT_EN
    tmo_en = 1;
`else
    tmo_en = 0;
`endif
    if (rst_in) begin
      model_reset();
    end else if (m_busy) begin
      m_to = 0;
      if (!r[m_owner]) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % N;
      end else if (tmo_en && m_age == HOLD) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % N;
        m_to   = 1;
      end else begin
        m_age++;
      end
    end else begin
      m_to = 0;
      if (e) begin
        for (int k = 0; k < N; k++) begin
          if (!m_busy && r[(m_ptr + k) % N]) begin
            m_busy  = 1;
            m_owner = (m_ptr + k) % N;
            m_age   = 1;
          end
        end
      end
    end
  endtask

  task automatic cycle(input logic e, input logic [3:0] r);
    exp_t x;
    en  = e;
    req = r;
    model_step(reset, e, r);
    x.g  = m_busy ? 4'(1 << m_owner) : 4'b0;
    x.id = m_busy ? 2'(m_owner) : 2'b0;
    x.b  = m_busy;
    x.to = m_to;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check("grant", 32'(grant), 32'(x.g));
    check("grant_id", 32'(grant_id), 32'(x.id));
    check("busy", 32'(busy), 32'(x.b));
    check("timeout", 32'(timeout), 32'(x.to));
    check("onehot0", 32'($onehot0(grant)), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] r;
    logic [3:0] prev;
    logic [3:0] got;
    logic [3:0] exp_order [5];
    logic [3:0] order[$];
    int gcnt, tcnt, n0;

    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    reset = 1'b1; en = 1'b0; req = '0;
    model_reset();

    // Reset held with all requests pending.
    repeat (5) cycle(1'b1, 4'b1111);
    reset = 1'b0;

    // Full rotation; each owner drops for one cycle after 3 granted cycles.
    prev = '0;
    for (int c = 0; c < 24; c++) begin
      r = 4'b1111;
      if (m_busy && m_age >= 3) r[m_owner] = 1'b0;
      cycle(1'b1, r);
      if (grant != 4'b0 && prev == 4'b0) order.push_back(grant);
      prev = grant;
    end
    check("t2_grants", 32'(order.size() >= 5), 32'd1);
    for (int k = 0; k < 5; k++) begin
      got = (k < order.size()) ? order[k] : 4'b0;
      check("t2_order", 32'(got), 32'(exp_order[k]));
    end
    repeat (2) cycle(1'b1, 4'b0000);

    // Single requester, then pointer wraps to requester 0.
    cycle(1'b1, 4'b0100);
    check("t3_grant", 32'(grant), 32'h4);
    check("t3_id", 32'(grant_id), 32'd2);
    cycle(1'b1, 4'b0100);
    cycle(1'b1, 4'b0000);
    cycle(1'b1, 4'b0101);
    check("t3_wrap", 32'(grant), 32'h1);
    cycle(1'b1, 4'b0100);
    cycle(1'b1, 4'b0000);

    // Enable gating and no preemption.
    repeat (3) cycle(1'b0, 4'b0010);
    check("t4_gated", 32'(grant), 32'h0);
    cycle(1'b1, 4'b0010);
    check("t4_grant", 32'(grant), 32'h2);
    repeat (3) cycle(1'b0, 4'b0010);
    check("t4_held", 32'(grant), 32'h2);
    cycle(1'b0, 4'b0000);
    check("t4_release", 32'(grant), 32'h0);
    cycle(1'b1, 4'b0000);

    // Asynchronous reset mid-grant.
    cycle(1'b1, 4'b1000);
    check("t5_pre", 32'(grant), 32'h8);
    #2 reset = 1'b1;
    #1;
    check("t5_async_grant", 32'(grant), 32'h0);
    check("t5_async_busy", 32'(busy), 32'h0);
    model_reset();
    #1 reset = 1'b0;
    cycle(1'b1, 4'b1111);
    check("t5_ptr", 32'(grant), 32'h1);
    cycle(1'b1, 4'b0000);
    cycle(1'b1, 4'b0000);

    // Long hold by requester 0.
`ifdef RR_ARB_TIMEOUT_EN
    n0 = HOLD + 1;
`else
    n0 = 20;
`endif
    gcnt = 0; tcnt = 0;
    for (int c = 0; c < n0; c++) begin
      cycle(1'b1, 4'b0001);
      if (grant == 4'b0001) gcnt++;
      if (timeout) tcnt++;
    end
    cycle(1'b1, 4'b0011);
`ifdef RR_ARB_TIMEOUT_EN
    check("t6_hold_len", 32'(gcnt), 32'(HOLD));
    check("t6_to_pulses", 32'(tcnt), 32'd1);
    check("t6_next", 32'(grant), 32'h2);
`else
    check("t6_hold_len", 32'(gcnt), 32'd20);
    check("t6_to_pulses", 32'(tcnt), 32'd0);
    check("t6_next", 32'(grant), 32'h1);
`endif
    cycle(1'b1, 4'b0000);
    cycle(1'b1, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
